// File: rtl/tcp_rx_ctrl_mp_pkg.sv
// Shared types and constants for the TCP receive control path:
// the FSM state encoding and the malloc attempt counter width.
package tcp_rx_ctrl_mp_pkg;

    localparam int MALLOC_RETRY_W = 4;

    typedef enum logic [3:0] {
        LOOKUP        = 4'd0,
        NEW_FLOW_REQ  = 4'd1,
        NEW_FLOW_WAIT = 4'd2,
        RD_STATE      = 4'd3,
        MALLOC_REQ    = 4'd4,
        MALLOC_RESP   = 4'd5,
        CALC          = 4'd6,
        WB_STATE      = 4'd7,
        WB_PAYLOAD    = 4'd8,
        SCHED         = 4'd9,
        PKT_OUT       = 4'd10
    } state_e;

    // True when another malloc attempt is still allowed after a failure.
    // cnt holds the number of failed attempts before the current one.
    function automatic logic retry_allowed(input logic [MALLOC_RETRY_W-1:0] cnt,
                                           input int max_attempts);
        return (int'(cnt) + 1) < max_attempts;
    endfunction

endpackage

// File: rtl/tcp_rx_ctrl_mp_hs_tracker.sv
// Sticky per-port completion tracker: each port's bit latches once its
// handshake fires and the whole set clears whenever the owning state is left.
module multi_port_hs_tracker #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic [N-1:0] fire,
    output logic [N-1:0] done,
    output logic         all_done
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= '0;
        end else if (!active) begin
            done <= '0;
        end else begin
            done <= done | fire;
        end
    end

    // Includes this cycle's handshakes so the owner can leave on the last one.
    assign all_done = active & (&(done | fire));

endmodule

// File: rtl/tcp_rx_ctrl_mp.sv
// Per-packet control FSM for the TCP receive path. Statistics counters are
// built only when TCP_RX_CTRL_STATS_EN is defined; otherwise they read 0.
module tcp_rx_ctrl_mp
    import tcp_rx_ctrl_mp_pkg::*;
#(
    parameter int NUM_RD_PORTS     = 4,
    parameter int NUM_WR_PORTS     = 3,
    parameter int MALLOC_RETRY_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    rx_tcp_hdr_val,
    output logic                    rx_hdr_rdy,

    output logic                    read_flow_cam_val,
    input  logic                    read_flow_cam_hit,
    output logic                    store_flowid_cam,

    output logic                    slow_path_val,
    input  logic                    slow_path_rdy,
    input  logic                    slow_path_done_val,
    output logic                    slow_path_done_rdy,

    output logic [NUM_RD_PORTS-1:0] st_rd_req_val,
    input  logic [NUM_RD_PORTS-1:0] st_rd_req_rdy,
    input  logic [NUM_RD_PORTS-1:0] st_rd_resp_val,
    output logic [NUM_RD_PORTS-1:0] st_rd_resp_rdy,

    output logic                    malloc_req_val,
    input  logic                    malloc_req_rdy,
    input  logic                    malloc_resp_val,
    input  logic                    malloc_resp_ok,
    output logic                    malloc_resp_rdy,

    output logic [NUM_WR_PORTS-1:0] st_wr_req_val,
    input  logic [NUM_WR_PORTS-1:0] st_wr_req_rdy,

    input  logic                    datap_ctrl_payload_accepted,
    output logic                    buf_store_wr_req_val,
    input  logic                    buf_store_wr_req_rdy,

    output logic                    sched_update_val,
    input  logic                    sched_update_rdy,
    output logic                    tcp_rx_dst_hdr_val,
    input  logic                    dst_tcp_rx_hdr_rdy,

    output logic                    ctrl_datap_save_input,
    output logic [NUM_RD_PORTS-1:0] ctrl_datap_save_flow_state,
    output logic                    ctrl_datap_save_malloc_resp,
    output logic                    ctrl_datap_save_calcs,
    output logic                    ctrl_datap_drop,

    output logic [31:0]             pkt_cnt,
    output logic [31:0]             drop_cnt,

    output logic [3:0]              fsm_state
);

    state_e                    state;
    logic                      drop;
    logic [MALLOC_RETRY_W-1:0] attempt_cnt;

    logic                      in_rd;
    logic                      in_wb;
    logic [NUM_RD_PORTS-1:0]   rd_req_done;
    logic [NUM_RD_PORTS-1:0]   rd_resp_done;
    logic [NUM_WR_PORTS-1:0]   wr_done;
    logic [NUM_RD_PORTS-1:0]   rd_req_fire;
    logic [NUM_RD_PORTS-1:0]   rd_resp_fire;
    logic [NUM_WR_PORTS-1:0]   wr_fire;
    logic                      rd_req_all;
    logic                      rd_resp_all;
    logic                      wr_all;
    logic                      store_needed;
    logic                      retry_ok;
    logic                      drop_decision;
    logic                      pkt_done;

    assign in_rd = (state == RD_STATE);
    assign in_wb = (state == WB_STATE);

    // A response is only acknowledged on a port whose request already went out.
    assign st_rd_req_val  = in_rd ? ~rd_req_done : '0;
    assign st_rd_resp_rdy = in_rd ? (rd_req_done & ~rd_resp_done) : '0;
    assign st_wr_req_val  = in_wb ? ~wr_done : '0;

    assign rd_req_fire  = st_rd_req_val & st_rd_req_rdy;
    assign rd_resp_fire = st_rd_resp_rdy & st_rd_resp_val;
    assign wr_fire      = st_wr_req_val & st_wr_req_rdy;

    assign ctrl_datap_save_flow_state = rd_resp_fire;

    multi_port_hs_tracker #(.N(NUM_RD_PORTS)) u_rd_req_trk (
        .clk      (clk),
        .rst      (rst),
        .active   (in_rd),
        .fire     (rd_req_fire),
        .done     (rd_req_done),
        .all_done (rd_req_all)
    );

    multi_port_hs_tracker #(.N(NUM_RD_PORTS)) u_rd_resp_trk (
        .clk      (clk),
        .rst      (rst),
        .active   (in_rd),
        .fire     (rd_resp_fire),
        .done     (rd_resp_done),
        .all_done (rd_resp_all)
    );

    multi_port_hs_tracker #(.N(NUM_WR_PORTS)) u_wr_trk (
        .clk      (clk),
        .rst      (rst),
        .active   (in_wb),
        .fire     (wr_fire),
        .done     (wr_done),
        .all_done (wr_all)
    );

    assign store_needed  = datap_ctrl_payload_accepted & ~drop;
    assign retry_ok      = retry_allowed(attempt_cnt, MALLOC_RETRY_MAX);
    assign drop_decision = (state == MALLOC_RESP) & malloc_resp_val & ~malloc_resp_ok & ~retry_ok;
    assign pkt_done      = (state == PKT_OUT) & dst_tcp_rx_hdr_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOOKUP;
            drop        <= 1'b0;
            attempt_cnt <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (rx_tcp_hdr_val) begin
                        drop        <= 1'b0;
                        attempt_cnt <= '0;
                        state       <= read_flow_cam_hit ? RD_STATE : NEW_FLOW_REQ;
                    end
                end
                NEW_FLOW_REQ: begin
                    if (slow_path_rdy) state <= NEW_FLOW_WAIT;
                end
                NEW_FLOW_WAIT: begin
                    // The header is still pending upstream and is looked up again.
                    if (slow_path_done_val) state <= LOOKUP;
                end
                RD_STATE: begin
                    if (rd_req_all && rd_resp_all) state <= MALLOC_REQ;
                end
                MALLOC_REQ: begin
                    if (malloc_req_rdy) state <= MALLOC_RESP;
                end
                MALLOC_RESP: begin
                    if (malloc_resp_val) begin
                        if (malloc_resp_ok) begin
                            state <= CALC;
                        end else if (retry_ok) begin
                            attempt_cnt <= attempt_cnt + 1'b1;
                            state       <= MALLOC_REQ;
                        end else begin
                            drop  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    state <= WB_STATE;
                end
                WB_STATE: begin
                    if (wr_all) state <= WB_PAYLOAD;
                end
                WB_PAYLOAD: begin
                    if (!store_needed || buf_store_wr_req_rdy) state <= SCHED;
                end
                SCHED: begin
                    if (sched_update_rdy) state <= PKT_OUT;
                end
                PKT_OUT: begin
                    if (dst_tcp_rx_hdr_rdy) state <= LOOKUP;
                end
                default: begin
                    state <= LOOKUP;
                end
            endcase
        end
    end

    always_comb begin
        rx_hdr_rdy                  = 1'b0;
        read_flow_cam_val           = 1'b0;
        store_flowid_cam            = 1'b0;
        ctrl_datap_save_input       = 1'b0;
        slow_path_val               = 1'b0;
        slow_path_done_rdy          = 1'b0;
        malloc_req_val              = 1'b0;
        malloc_resp_rdy             = 1'b0;
        ctrl_datap_save_malloc_resp = 1'b0;
        ctrl_datap_save_calcs       = 1'b0;
        buf_store_wr_req_val        = 1'b0;
        sched_update_val            = 1'b0;
        tcp_rx_dst_hdr_val          = 1'b0;
        case (state)
            LOOKUP: begin
                rx_hdr_rdy            = 1'b1;
                ctrl_datap_save_input = 1'b1;
                store_flowid_cam      = 1'b1;
                read_flow_cam_val     = rx_tcp_hdr_val;
            end
            NEW_FLOW_REQ:  slow_path_val      = 1'b1;
            NEW_FLOW_WAIT: slow_path_done_rdy = 1'b1;
            MALLOC_REQ:    malloc_req_val     = 1'b1;
            MALLOC_RESP: begin
                malloc_resp_rdy             = 1'b1;
                ctrl_datap_save_malloc_resp = 1'b1;
            end
            CALC:          ctrl_datap_save_calcs = 1'b1;
            WB_PAYLOAD:    buf_store_wr_req_val  = store_needed;
            SCHED:         sched_update_val      = 1'b1;
            PKT_OUT:       tcp_rx_dst_hdr_val    = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_datap_drop = drop & (state inside {CALC, WB_STATE, WB_PAYLOAD, SCHED, PKT_OUT});
    assign fsm_state       = state;

`ifdef TCP_RX_CTRL_STATS_EN
    logic [31:0] pkt_q;
    logic [31:0] drop_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (pkt_done)      pkt_q  <= pkt_q + 32'd1;
            if (drop_decision) drop_q <= drop_q + 32'd1;
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
`else
    logic unused_stats;
    assign unused_stats = pkt_done ^ drop_decision;
    assign pkt_cnt      = '0;
    assign drop_cnt     = '0;
`endif

endmodule

// File: doc/tcp_rx_ctrl_mp.md
TCP_RX_CTRL_MP -- requirements
Module: tcp_rx_ctrl_mp

Interface
- REQ-001 Param NUM_RD_PORTS, default 4: number of per-flow state read ports (rx state, tx state, head idx, tail idx, ...), range 1..8.
- REQ-002 Param NUM_WR_PORTS, default 3: number of per-flow state writeback ports, range 1..8.
- REQ-003 Param MALLOC_RETRY_MAX, default 4: malloc attempts before a packet's payload is dropped, range 1..15.
- REQ-004 clk  in  1  sole clock; all logic is on its rising edge.
- REQ-005 rst  in  1  reset, asynchronous, active-low.
- REQ-006 rx_tcp_hdr_val in 1 / rx_hdr_rdy out 1: incoming header handshake.
- REQ-007 read_flow_cam_val out 1 / read_flow_cam_hit in 1 / store_flowid_cam out 1: flow CAM lookup.
- REQ-008 slow_path_val out 1 / slow_path_rdy in 1 / slow_path_done_val in 1 / slow_path_done_rdy out 1: new-flow setup.
- REQ-009 st_rd_req_val out NUM_RD_PORTS / st_rd_req_rdy in NUM_RD_PORTS / st_rd_resp_val in NUM_RD_PORTS / st_rd_resp_rdy out NUM_RD_PORTS: per-port state reads.
- REQ-010 malloc_req_val out 1 / malloc_req_rdy in 1 / malloc_resp_val in 1 / malloc_resp_ok in 1 / malloc_resp_rdy out 1: buffer allocation.
- REQ-011 st_wr_req_val out NUM_WR_PORTS / st_wr_req_rdy in NUM_WR_PORTS: per-port state writeback.
- REQ-012 datap_ctrl_payload_accepted in 1 / buf_store_wr_req_val out 1 / buf_store_wr_req_rdy in 1: payload store.
- REQ-013 sched_update_val out 1 / sched_update_rdy in 1; tcp_rx_dst_hdr_val out 1 / dst_tcp_rx_hdr_rdy in 1.
- REQ-014 Datapath strobes, all out: ctrl_datap_save_input 1, ctrl_datap_save_flow_state NUM_RD_PORTS, ctrl_datap_save_malloc_resp 1, ctrl_datap_save_calcs 1, ctrl_datap_drop 1.
- REQ-015 pkt_cnt out 32 and drop_cnt out 32: statistics counters.

Function
- REQ-016 FSM states: LOOKUP, NEW_FLOW_REQ, NEW_FLOW_WAIT, RD_STATE, MALLOC_REQ, MALLOC_RESP, CALC, WB_STATE, WB_PAYLOAD, SCHED, PKT_OUT.
- REQ-017 LOOKUP:
  - Asserts rx_hdr_rdy, ctrl_datap_save_input and store_flowid_cam.
  - read_flow_cam_val = rx_tcp_hdr_val.
  - On header accept, goes to RD_STATE on a hit, else to NEW_FLOW_REQ.
- REQ-018 NEW_FLOW_REQ holds slow_path_val until slow_path_rdy, then goes to NEW_FLOW_WAIT.
- REQ-019 NEW_FLOW_WAIT asserts slow_path_done_rdy; on slow_path_done_val it returns to LOOKUP (header re-presented).
- REQ-020 RD_STATE uses sticky per-port req_done and resp_done bits, cleared on entry.
  - st_rd_req_val[i] = ~req_done[i].
  - st_rd_resp_rdy[i] = req_done[i] & ~resp_done[i].
  - ctrl_datap_save_flow_state[i] pulses on resp accept.
  - Exits to MALLOC_REQ the cycle after all resp_done bits are set.
  - Ports complete independently, in any order.
- REQ-021 A response on a port whose request is not yet accepted is not acknowledged (rdy stays 0).
- REQ-022 Malloc request: MALLOC_REQ holds malloc_req_val until malloc_req_rdy, then goes to MALLOC_RESP.
- REQ-023 Malloc response: MALLOC_RESP asserts malloc_resp_rdy and ctrl_datap_save_malloc_resp. On malloc_resp_val:
  - ok=1: go to CALC.
  - ok=0 and attempts < MALLOC_RETRY_MAX: increment the 4-bit attempt counter and return to MALLOC_REQ.
  - otherwise: set the drop flag and go to CALC.
- REQ-024 CALC pulses ctrl_datap_save_calcs for one cycle, then goes to WB_STATE.
- REQ-025 WB_STATE uses the same sticky scheme on st_wr_req; it exits to WB_PAYLOAD once all ports are done.
- REQ-026 WB_PAYLOAD:
  - buf_store_wr_req_val = payload_accepted & ~drop.
  - Goes to SCHED on handshake, or immediately if no store is needed.
- REQ-027 SCHED holds sched_update_val until sched_update_rdy, then goes to PKT_OUT.
- REQ-028 PKT_OUT holds tcp_rx_dst_hdr_val until dst_tcp_rx_hdr_rdy, then returns to LOOKUP.
- REQ-029 ctrl_datap_drop equals the drop flag from CALC through PKT_OUT.
- REQ-030 The drop flag and attempt counter clear on LOOKUP exit.
- REQ-031 Once asserted, every valid is held stable until its handshake completes.
- REQ-032 Latency: a CAM-hit packet with all sinks ready and 1-cycle responses reaches PKT_OUT accept in 9 cycles.

Reset
- REQ-033 While rst=0, the FSM is in LOOKUP, all sticky bits, counters, the attempt counter and the drop flag are 0, and all outputs are 0 except the LOOKUP combinational outputs.
- REQ-034 Reset asserted mid-packet abandons the packet; no handshake completes after reset deassertion except from LOOKUP.

Configuration
- REQ-035 Macro TCP_RX_CTRL_STATS_EN controls the statistics counters.
  - Defined: pkt_cnt increments at PKT_OUT handshake; drop_cnt increments on the drop decision; both wrap modulo 2^32.
  - Undefined: no counter registers; pkt_cnt and drop_cnt are tied to 0.

Structure
- REQ-036 Package tcp_rx_ctrl_mp_pkg holds the state enum and the MALLOC_RETRY_W=4 constant.
- REQ-037 The sticky multi-port handshake tracker is the sub-module multi_port_hs_tracker (param N), instantiated for both RD_STATE and WB_STATE.

Verification
- REQ-038 Miss, then slow path done after 5 cycles, then hit: slow_path_val seen once; the second header pass reaches PKT_OUT.
- REQ-039 NUM_RD_PORTS=4 with rdy skewed (port 3 req accepted at cycle +7): exit RD_STATE only after the port 3 response; each save_flow_state bit pulses exactly once.
- REQ-040 malloc_resp_ok=0 twice then 1 (MAX=4): three malloc requests; drop=0; buf_store issued.
- REQ-041 malloc_resp_ok=0 four times: drop=1; no buf_store_wr_req_val; all WB ports still written; drop_cnt=1.
- REQ-042 rst pulled low in WB_STATE: outputs idle next edge; a fresh packet completes normally; pkt_cnt counts only completed packets (STATS_EN on); counters read 0 with STATS_EN off.
